// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with registered response; define ALU_SEQ_MUL_EN to add the iterative unsigned MUL
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);
`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ma, mb, acc_n;
  logic             alu_mul, last;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
  state_t           state, state_n;
  logic             armed, accept, alu_err;
  logic [WIDTH-1:0] alu_res;

  // armed keeps req_ready low until the first edge after reset release
  assign req_ready  = armed && state == IDLE;
  assign resp_valid = state == DONE;
  assign accept     = req_valid && req_ready;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    alu_mul = 1'b0;
`endif
    case (opcode)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: alu_res = A + B;
      4'b0100: alu_res = A ^ B;
      4'b0101: alu_res = ~(A | B);
      4'b0110: alu_res = A - B;
      4'b0111: alu_res = WIDTH'($signed(A) < $signed(B));
      4'b1010: alu_res = A << B[4:0];
`ifdef ALU_SEQ_MUL_EN
      4'b1000: alu_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
`ifdef ALU_SEQ_MUL_EN
      IDLE: state_n = accept ? (alu_mul ? BUSY : DONE) : IDLE;
      BUSY: state_n = last ? DONE : BUSY;
`else
      IDLE: state_n = accept ? DONE : IDLE;
`endif
      DONE: state_n = resp_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // result doubles as the shift-add accumulator while BUSY
  assign last  = cnt == CW'(WIDTH - 1);
  assign acc_n = result + (mb[0] ? ma : '0);
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt    <= '0;
      ma     <= '0;
      mb     <= '0;
`endif
    end else begin
      armed <= 1'b1;
      if (accept) begin
        result <= alu_res;
        zero   <= alu_res == '0;
        err    <= alu_err;
`ifdef ALU_SEQ_MUL_EN
        cnt    <= '0;
        ma     <= A;
        mb     <= B;
      end else if (state == BUSY) begin
        result <= acc_n;
        ma     <= ma << 1;
        mb     <= mb >> 1;
        cnt    <= cnt + CW'(1);
        if (last) zero <= acc_n == '0;
`endif
      end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: vector table, directed corner sequences and random ops against a plain-arithmetic model
module tb_alu_seq_unit;
  localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk, rst_n, req_valid, req_ready, resp_valid, resp_ready, zero, err;
  logic [W-1:0] A, B, result;
  logic [3:0]   opcode;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .A(A), .B(B), .opcode(opcode), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .zero(zero), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         e;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
  endtask

  // {err, result} straight from the opcode definitions
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'h0: return {1'b0, a & b};
      4'h1: return {1'b0, a | b};
      4'h2: return {1'b0, a + b};
      4'h4: return {1'b0, a ^ b};
      4'h5: return {1'b0, ~(a | b)};
      4'h6: return {1'b0, a - b};
      4'h7: return {1'b0, W'($signed(a) < $signed(b))};
      4'hA: return {1'b0, a << b[4:0]};
      4'h8: return MUL_EN ? {1'b0, p[W-1:0]} : {1'b1, {W{1'b0}}};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        output logic [W-1:0] r, output logic z, output logic e,
                        output int lat, output int rdy);
    int n;
    n = 0;
    rdy = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    A = a; B = b; opcode = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    A = ~a; B = ~b;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      if (req_ready) rdy++;
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = zero; e = err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input logic [W-1:0] er, input logic ee);
    logic [W-1:0] r;
    logic z, e;
    int lat, rdy;
    run_op(a, b, op, r, z, e, lat, rdy);
    chk({nm, ".result"}, r, er);
    chk({nm, ".zero"}, z, er == '0);
    chk({nm, ".err"}, e, ee);
    chk({nm, ".latency"}, lat, (MUL_EN && op == 4'h8) ? W + 1 : 1);
    chk({nm, ".ready_while_pending"}, rdy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] la, lb, ra, rb;
    logic [3:0]   rop;
    logic [W:0]   m;
    tbl[0]  = '{32'd15, 32'd10, 4'h0, 32'd10, 1'b0};
    tbl[1]  = '{32'd15, 32'd10, 4'h1, 32'd15, 1'b0};
    tbl[2]  = '{32'd15, 32'd10, 4'h2, 32'd25, 1'b0};
    tbl[3]  = '{32'd15, 32'd10, 4'h6, 32'd5, 1'b0};
    tbl[4]  = '{32'd5, 32'd5, 4'h6, 32'd0, 1'b0};
    tbl[5]  = '{32'hFFFF_FFFF, 32'd0, 4'h7, 32'd1, 1'b0};
    tbl[6]  = '{32'hFFFF_FFFF, 32'd1, 4'h2, 32'd0, 1'b0};
    tbl[7]  = '{32'hFFFF_FFFF, 32'd1, 4'hB, 32'd0, 1'b1};
    tbl[8]  = '{32'h0000_F0F0, 32'h0000_0FF0, 4'h4, 32'h0000_FF00, 1'b0};
    tbl[9]  = '{32'd0, 32'd0, 4'h5, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{32'd1, 32'd31, 4'hA, 32'h8000_0000, 1'b0};
    tbl[11] = '{32'd3, 32'h25, 4'hA, 32'h60, 1'b0};
    tbl[12] = '{32'd1, 32'hFFFF_FFFF, 4'h7, 32'd0, 1'b0};
    tbl[13] = '{32'hFFFF_FFFE, 32'd1, 4'h7, 32'd1, 1'b0};
    tbl[14] = '{32'h1234_5678, 32'd0, 4'h3, 32'd0, 1'b1};
    tbl[15] = '{32'd5, 32'd7, 4'h6, 32'hFFFF_FFFE, 1'b0};
    tbl[16] = '{32'd15, 32'd10, 4'hF, 32'd0, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; A = '0; B = '0; opcode = '0;
    #12;
    chk("reset.req_ready", req_ready, 0);
    chk("reset.resp_valid", resp_valid, 0);
    chk("reset.result", result, 0);
    chk("reset.zero", zero, 0);
    chk("reset.err", err, 0);
    rst_n = 1'b1;
    #1;
    chk("release.ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    chk("release.ready_after_edge", req_ready, 1);

    foreach (tbl[i]) check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].e);

    check_op("mul", 32'd15, 32'd10, 4'h8, MUL_EN ? 32'd150 : 32'd0, !MUL_EN);

    // response held while inputs churn and a new request waits
    A = 32'd15; B = 32'd10; opcode = 4'h2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold.resp_valid", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      la = $urandom; lb = $urandom;
      A = la; B = lb; opcode = 4'h0; req_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold%0d.result", i), result, 25);
      chk($sformatf("hold%0d.req_ready", i), req_ready, 0);
      chk($sformatf("hold%0d.resp_valid", i), resp_valid, 1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("hold.released_idle", req_ready, 1);
    chk("hold.released_valid", resp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold.next_valid", resp_valid, 1);
    chk("hold.next_result", result, la & lb);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // reset mid-operation discards the pending response
    A = 32'd15; B = 32'd10; opcode = 4'h8; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort.pre_state", resp_valid, !MUL_EN);
    rst_n = 1'b0;
    #1;
    chk("abort.resp_valid", resp_valid, 0);
    chk("abort.result", result, 0);
    chk("abort.req_ready", req_ready, 0);
    chk("abort.err", err, 0);
    chk("abort.zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.ready_after_release", req_ready, 1);
    check_op("abort.add", 32'd3, 32'd4, 4'h2, 32'd7, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      rop = 4'($urandom_range(0, 15));
      m = model(ra, rb, rop);
      check_op($sformatf("rand%0d_op%0h", i, rop), ra, rb, rop, m[W-1:0], m[W]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 8..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, which SHALL mean the requester presents an operation.
REQ-005 The block SHALL have port req_ready, output, 1, which SHALL mean the block accepts an operation this cycle.
REQ-006 The block SHALL have ports A and B, input, WIDTH, the operands.
REQ-007 The block SHALL have port opcode, input, 4, the operation select.
REQ-008 The block SHALL have port resp_valid, output, 1, which SHALL mean result, zero and err are valid.
REQ-009 The block SHALL have port resp_ready, input, 1, which SHALL mean the requester consumes the response.
REQ-010 The block SHALL have port result, output, WIDTH, the operation result.
REQ-011 The block SHALL have port zero, output, 1, set when result equals 0.
REQ-012 The block SHALL have port err, output, 1, set for an unsupported opcode.

Function
REQ-013 The block SHALL accept a request on a clock edge where req_valid and req_ready are both 1, and SHALL capture A, B and opcode on that edge.
REQ-014 The state machine SHALL have states IDLE, BUSY and DONE; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in DONE.
REQ-015 Transitions: IDLE->DONE on accept of a single-cycle op; IDLE->BUSY on accept of MUL; BUSY->DONE when the iteration counter reaches WIDTH; DONE->IDLE on resp_ready=1.
REQ-016 Opcode map: 0000 AND; 0001 OR; 0010 ADD; 0100 XOR; 0101 NOR; 0110 SUB (A-B); 0111 SLT (signed, result 1 or 0); 1010 SLL (A shifted left by B[4:0]); 1000 MUL (per REQ-026).
REQ-017 ADD, SUB and MUL SHALL return the low WIDTH bits; carry and overflow SHALL be discarded, i.e. results wrap modulo 2^WIDTH.
REQ-018 Any other opcode, including X/Z bits, SHALL give result=0, zero=1 and err=1 with single-cycle latency; err SHALL be 0 for legal opcodes.
REQ-019 Single-cycle ops: if accepted at edge N, resp_valid SHALL be 1 after edge N+1.
REQ-020 result, zero and err SHALL be registered, and SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-021 Changes on A, B or opcode after acceptance SHALL NOT affect the pending response.
REQ-022 A request presented while req_ready=0 SHALL be ignored, not queued; back-to-back throughput SHALL be at most one op per 2 cycles, because DONE->IDLE->accept.
REQ-023 resp_ready asserted outside DONE SHALL have no effect.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, req_ready=0, resp_valid=0, result=0, zero=0, err=0 and counter=0, without waiting for a clock edge.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation and discard the response; req_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-026 With macro ALU_SEQ_MUL_EN defined, opcode 1000 SHALL be an unsigned iterative shift-add multiply: one bit per cycle, WIDTH cycles in BUSY, resp_valid after edge N+WIDTH+1.
REQ-027 Without ALU_SEQ_MUL_EN, the BUSY state and the counter SHALL be absent, and opcode 1000 SHALL be treated as unsupported per REQ-018.

Verification
REQ-028 Scenario 1: A=15, B=10, apply opcodes 0000, 0001, 0010, 0110 in turn -> results 10, 15, 25, 5; zero=0 and err=0 for each.
REQ-029 Scenario 2: A=5, B=5, opcode 0110 -> result=0, zero=1; then A=-1, B=0, opcode 0111 -> result=1.
REQ-030 Scenario 3: A=0xFFFFFFFF, B=1, opcode 0010 -> result=0, zero=1 (wrap-around); opcode 1011 -> result=0, err=1.
REQ-031 Scenario 4: with ALU_SEQ_MUL_EN, A=15, B=10, opcode 1000 -> resp_valid exactly 33 cycles after accept, result=150; req_ready=0 throughout.
REQ-032 Scenario 5: hold resp_ready=0 for 5 cycles in DONE while changing A and B -> result stays constant; req_ready stays 0; a new request is accepted only after the resp_ready handshake.
REQ-033 Scenario 6: assert rst_n=0 mid-MUL (cycle 10 of BUSY) -> resp_valid=0 and result=0 immediately; after release, a fresh ADD 3+4 returns 7.
